// File: rtl/othello_task_feeder_if.sv
// Host board stream, solver pipeline drive/return and result stream of the task feeder.
// master = feeder side, slave = host/pipeline side.
interface othello_task_feeder_if #(
  parameter int TAG_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [63:0]             in_player;
  logic [63:0]             in_opponent;
  logic [TAG_W-1:0]        in_tag;

  logic                    pl_enable;
  logic [63:0]             pl_player;
  logic [63:0]             pl_opponent;
  logic                    pl_solved;
  logic signed [7:0]       pl_res;
  logic [63:0]             pl_oplayer;
  logic [63:0]             pl_oopponent;

  logic                    out_valid;
  logic                    out_ready;
  logic [TAG_W-1:0]        out_tag;
  logic signed [7:0]       out_score;
  logic [63:0]             out_player;
  logic [63:0]             out_opponent;

  modport master (
    input  in_valid, in_player, in_opponent, in_tag,
    input  pl_solved, pl_res, pl_oplayer, pl_oopponent,
    input  out_ready,
    output in_ready, pl_enable, pl_player, pl_opponent,
    output out_valid, out_tag, out_score, out_player, out_opponent
  );

  modport slave (
    output in_valid, in_player, in_opponent, in_tag,
    output pl_solved, pl_res, pl_oplayer, pl_oopponent,
    output out_ready,
    input  in_ready, pl_enable, pl_player, pl_opponent,
    input  out_valid, out_tag, out_score, out_player, out_opponent
  );
endinterface

// File: rtl/othello_task_feeder.sv
// Feeds tagged boards into the interleaved endgame solver and collects the
// per-thread results into a credit-limited result FIFO.
//
//  state | meaning
//  IDLE  | pipeline disabled, waiting for iRun
//  PRIME | one load per cycle, THREADS cycles, fills every thread
//  RUN   | reload the thread that just solved
//  DRAIN | reload with fillers only until no real board is outstanding
module othello_task_feeder #(
  parameter int THREADS   = 7,
  parameter int TAG_W     = 8,
  parameter int RES_DEPTH = 8
) (
  input  logic                   iCLOCK,
  input  logic                   iRESET,
  input  logic                   iRun,
  othello_task_feeder_if.master  bus,
  output logic                   busy
);
  localparam int PTR_W   = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam int OUT_W   = $clog2(THREADS + 1);
  localparam int CNT_W   = $clog2(RES_DEPTH + 1);
  localparam int AW      = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int ENTRY_W = TAG_W + 8 + 128;
  localparam logic [63:0] FILL_PLAYER = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;

  state_t             state;
  logic               pl_enable_q;
  logic               busy_q;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   prime_cnt;
  logic [THREADS-1:0] slot_valid;
  logic [TAG_W-1:0]   slot_tag [THREADS];
  logic [OUT_W-1:0]   outstanding;

  logic [ENTRY_W-1:0] fifo_mem [RES_DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [CNT_W-1:0]   fifo_count;

  logic               load;
  logic               take;
  logic               real_solve;
  logic               pop;
  logic               credit_ok;
  logic [CNT_W:0]     credit_sum;

  assign load = (state == PRIME) ||
                (((state == RUN) || (state == DRAIN)) && bus.pl_solved);

  // Results already parked in the FIFO still hold a credit until the host takes them.
  assign credit_sum = (CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count);
  assign credit_ok  = credit_sum < (CNT_W+1)'(RES_DEPTH);

  assign take       = load && (state != DRAIN) && bus.in_valid && credit_ok;
  assign real_solve = bus.pl_solved && slot_valid[ptr] && (state != IDLE);
  assign pop        = bus.out_valid && bus.out_ready;

  assign bus.in_ready    = take;
  assign bus.pl_player   = take ? bus.in_player   : FILL_PLAYER;
  assign bus.pl_opponent = take ? bus.in_opponent : 64'h0;
  assign bus.pl_enable   = pl_enable_q;
  assign busy            = busy_q;

  assign bus.out_valid = (fifo_count != '0);
  assign {bus.out_tag, bus.out_score, bus.out_player, bus.out_opponent} = fifo_mem[rd_ptr];

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state       <= IDLE;
      pl_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr         <= '0;
      prime_cnt   <= '0;
    end else begin
      if (pl_enable_q)
        ptr <= (ptr == PTR_W'(THREADS - 1)) ? '0 : ptr + 1'b1;
      case (state)
        IDLE: begin
          if (iRun) begin
            state       <= PRIME;
            prime_cnt   <= PTR_W'(THREADS - 1);
            pl_enable_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        PRIME: begin
          if (prime_cnt == '0)
            state <= RUN;
          else
            prime_cnt <= prime_cnt - 1'b1;
        end
        RUN: begin
          if (!iRun)
            state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state       <= IDLE;
            pl_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr         <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      slot_valid  <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (load)
        slot_valid[ptr] <= take;
      case ({take, real_solve})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (real_solve)
        wr_ptr <= (wr_ptr == AW'(RES_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(RES_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({real_solve, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Tag is read for the push before the same slot is reloaded this cycle.
  always_ff @(posedge iCLOCK) begin
    if (take)
      slot_tag[ptr] <= bus.in_tag;
    if (real_solve && !iRESET)
      fifo_mem[wr_ptr] <= {slot_tag[ptr], bus.pl_res, bus.pl_oplayer, bus.pl_oopponent};
  end
endmodule

// File: tb/tb_othello_task_feeder.sv
// Randomized scoreboard bench for othello_task_feeder with a stub interleaved
// solver: each thread solves after a tag-derived number of visits.
module tb_othello_task_feeder;
  localparam int THREADS   = 7;
  localparam int TAG_W     = 8;
  localparam int RES_DEPTH = 8;

  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] pl;
    logic [63:0] op;
  } board_t;

  typedef struct packed {
    logic [7:0]  tag;
    logic [7:0]  score;
    logic [63:0] pl;
    logic [63:0] op;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic busy;

  othello_task_feeder_if #(.TAG_W(TAG_W)) bus();

  othello_task_feeder #(.THREADS(THREADS), .TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH)) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .iRun   (run),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_pop    = 0;

  board_t host_q[$];
  res_t   sb_q[$];
  logic [7:0] pop_tags[$];
  logic [7:0] last_tag;
  logic [7:0] last_score;

  // stub pipeline state
  board_t t_brd  [THREADS];
  bit     t_busy [THREADS];
  bit     t_real [THREADS];
  int     t_rem  [THREADS];
  int     stub_ptr = 0;

  bit rst_req = 1'b0;
  bit run_cmd = 1'b0;
  bit offer = 1'b0;
  bit probe = 1'b0;
  bit run_mode = 1'b1;
  bit rnd_ready = 1'b0;
  bit out_rdy_fixed = 1'b1;
  bit arm_rst = 1'b0;
  int valid_pct = 100;

  task automatic chk(input bit ok, input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic board_t mk_board(input logic [7:0] tag);
    board_t b;
    b.tag = tag;
    b.pl  = {$urandom, $urandom};
    b.op  = {$urandom, $urandom} & ~b.pl;
    return b;
  endfunction

  function automatic logic [7:0] stub_res(input logic [7:0] tag);
    return tag - 8'd54;
  endfunction

  task automatic clear_stub();
    for (int i = 0; i < THREADS; i++) begin
      t_busy[i] = 1'b0;
      t_real[i] = 1'b0;
      t_rem[i]  = 0;
      t_brd[i]  = '0;
    end
    stub_ptr = 0;
  endtask

  task automatic step();
    int     thr;
    int     n_real;
    bit     en, solve_now, free, credit, exp_rdy, from_q;
    board_t hb;
    res_t   r;
    @(negedge clk);
    rst     = rst_req;
    rst_req = 1'b0;
    run     = run_cmd;
    from_q  = 1'b0;
    hb      = '0;
    if (probe)
      hb = mk_board(8'($urandom));
    else if (offer && host_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      hb     = host_q[0];
      from_q = 1'b1;
    end
    bus.in_valid    = probe || from_q;
    bus.in_tag      = hb.tag;
    bus.in_player   = hb.pl;
    bus.in_opponent = hb.op;
    bus.out_ready   = rnd_ready ? 1'($urandom_range(1)) : out_rdy_fixed;

    thr       = stub_ptr;
    en        = bus.pl_enable;
    solve_now = en && t_busy[thr] && (t_rem[thr] == 1);
    bus.pl_solved    = solve_now;
    bus.pl_res       = (solve_now && t_real[thr]) ? stub_res(t_brd[thr].tag) : 8'h0;
    bus.pl_oplayer   = solve_now ? t_brd[thr].pl : 64'h0;
    bus.pl_oopponent = solve_now ? t_brd[thr].op : 64'h0;
    if (arm_rst && solve_now && t_real[thr]) begin
      rst     = 1'b1;
      arm_rst = 1'b0;
    end
    #1;
    if (rst) begin
      clear_stub();
      sb_q.delete();
      return;
    end
    if (!en) begin
      chk(bus.in_ready == 1'b0, "in_ready_disabled", bus.in_ready, 0);
      clear_stub();
      return;
    end
    n_real = 0;
    for (int i = 0; i < THREADS; i++)
      if (t_busy[i] && t_real[i]) n_real++;
    credit  = (n_real + sb_q.size()) < RES_DEPTH;
    free    = !t_busy[thr] || solve_now;
    exp_rdy = free && bus.in_valid && run_mode && credit;
    chk(bus.in_ready == exp_rdy, "in_ready", bus.in_ready, exp_rdy);
    if (solve_now && t_real[thr]) begin
      r.tag   = t_brd[thr].tag;
      r.score = stub_res(t_brd[thr].tag);
      r.pl    = t_brd[thr].pl;
      r.op    = t_brd[thr].op;
      sb_q.push_back(r);
    end
    if (free) begin
      t_busy[thr] = 1'b1;
      if (bus.in_ready) begin
        chk({bus.pl_player, bus.pl_opponent} == {hb.pl, hb.op}, "load_board",
            {bus.pl_player, bus.pl_opponent}, {hb.pl, hb.op});
        t_brd[thr]  = hb;
        t_real[thr] = 1'b1;
        t_rem[thr]  = 1 + int'(hb.tag[1:0]);
        n_acc++;
        if (from_q) void'(host_q.pop_front());
      end else begin
        chk({bus.pl_player, bus.pl_opponent} == {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, "filler_board",
            {bus.pl_player, bus.pl_opponent}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        t_brd[thr]  = '0;
        t_real[thr] = 1'b0;
        t_rem[thr]  = 1;
      end
    end else begin
      t_rem[thr]--;
    end
    stub_ptr = (thr + 1) % THREADS;
  endtask

  // result monitor
  initial begin
    res_t got, e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
        got = {bus.out_tag, bus.out_score, bus.out_player, bus.out_opponent};
        chk(sb_q.size() != 0, "result_expected", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk(got == e, "result", got, e);
        end
        n_pop++;
        pop_tags.push_back(bus.out_tag);
        last_tag   = bus.out_tag;
        last_score = bus.out_score;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    run_cmd = 1'b0;
    offer   = 1'b0;
    probe   = 1'b0;
    host_q.delete();
    rst_req = 1'b1;
    step();
    step();
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int k = 0;
    while (n_pop < target && k < budget) begin
      step();
      k++;
    end
    chk(n_pop == target, name, n_pop, target);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    run_cmd = 1'b0;
    do begin
      step();
      k++;
    end while (busy && k < budget);
    chk(busy == 1'b0, name, busy, 0);
    chk(bus.pl_enable == 1'b0, "pl_enable_idle", bus.pl_enable, 0);
  endtask

  initial begin
    int a0, p0, ones, k;
    logic [7:0] exp3 [4];
    bus.in_valid = 0; bus.in_player = 0; bus.in_opponent = 0; bus.in_tag = 0;
    bus.pl_solved = 0; bus.pl_res = 0; bus.pl_oplayer = 0; bus.pl_oopponent = 0;
    bus.out_ready = 1;
    clear_stub();

    // reset state
    do_reset();
    chk(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
    chk(bus.pl_enable == 1'b0, "rst_pl_enable", bus.pl_enable, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);

    // seven queued boards fill every thread during PRIME
    for (int i = 0; i < 7; i++) host_q.push_back(mk_board(8'(i)));
    p0 = n_pop;
    offer = 1'b1;
    run_cmd = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!busy && k < 20);
    chk(busy == 1'b1, "prime_start", busy, 1);
    ones = int'(bus.in_ready);
    for (int i = 0; i < 6; i++) begin
      step();
      ones += int'(bus.in_ready);
    end
    chk(ones == 7, "prime_7_loads", ones, 7);
    wait_pops(p0 + 7, 400, "t1_results");
    wait_idle(300, "t1_idle");

    // single board, fillers never produce results
    do_reset();
    p0 = n_pop;
    host_q.push_back(mk_board(8'h2A));
    offer = 1'b1;
    run_cmd = 1'b1;
    wait_pops(p0 + 1, 300, "t2_one_result");
    for (int i = 0; i < 60; i++) step();
    chk(n_pop == p0 + 1, "t2_only_one", n_pop - p0, 1);
    chk(last_tag == 8'h2A, "t2_tag", last_tag, 8'h2A);
    chk(last_score == 8'hF4, "t2_score_m12", last_score, 8'hF4);
    wait_idle(300, "t2_idle");

    // out-of-order completion: thread 3 solves before thread 1
    do_reset();
    p0 = n_pop;
    pop_tags.delete();
    exp3[0] = 8'h10; exp3[1] = 8'h20; exp3[2] = 8'h30; exp3[3] = 8'h13;
    host_q.push_back(mk_board(8'h10));
    host_q.push_back(mk_board(8'h13));
    host_q.push_back(mk_board(8'h20));
    host_q.push_back(mk_board(8'h30));
    offer = 1'b1;
    run_cmd = 1'b1;
    wait_pops(p0 + 4, 400, "t3_results");
    for (int i = 0; i < 4; i++)
      chk(pop_tags.size() > i && pop_tags[i] == exp3[i], "t3_order",
          (pop_tags.size() > i) ? pop_tags[i] : 8'hxx, exp3[i]);
    wait_idle(300, "t3_idle");

    // credit limit with a stalled host
    do_reset();
    p0 = n_pop;
    a0 = n_acc;
    out_rdy_fixed = 1'b0;
    for (int i = 0; i < 20; i++) host_q.push_back(mk_board(8'($urandom)));
    offer = 1'b1;
    run_cmd = 1'b1;
    for (int i = 0; i < 150; i++) step();
    chk(n_acc - a0 == RES_DEPTH, "t4_credit_stop", n_acc - a0, RES_DEPTH);
    chk(bus.out_valid == 1'b1, "t4_fifo_holding", bus.out_valid, 1);
    out_rdy_fixed = 1'b1;
    wait_pops(p0 + 20, 3000, "t4_all_results");
    wait_idle(300, "t4_idle");

    // drain with three boards in flight
    do_reset();
    p0 = n_pop;
    a0 = n_acc;
    host_q.push_back(mk_board(8'h43));
    host_q.push_back(mk_board(8'h57));
    host_q.push_back(mk_board(8'h6B));
    offer = 1'b1;
    run_cmd = 1'b1;
    k = 0;
    while (n_acc - a0 < 3 && k < 30) begin
      step();
      k++;
    end
    chk(n_acc - a0 == 3, "t5_three_loaded", n_acc - a0, 3);
    run_cmd = 1'b0;
    for (int i = 0; i < 10; i++) step();
    run_mode = 1'b0;
    probe = 1'b1;
    wait_idle(300, "t5_idle");
    chk(n_pop - p0 == 3, "t5_three_results", n_pop - p0, 3);
    for (int i = 0; i < 8; i++) step();
    chk(busy == 1'b0, "t5_stays_idle", busy, 0);
    probe = 1'b0;
    run_mode = 1'b1;

    // reset coinciding with a real solve
    do_reset();
    for (int i = 0; i < 10; i++) host_q.push_back(mk_board(8'($urandom)));
    offer = 1'b1;
    run_cmd = 1'b1;
    arm_rst = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!rst && k < 300);
    chk(rst == 1'b1, "t6_reset_hit", rst, 1);
    arm_rst = 1'b0;
    run_cmd = 1'b0;
    offer = 1'b0;
    host_q.delete();
    step();
    chk(bus.out_valid == 1'b0, "t6_no_push", bus.out_valid, 0);
    chk(bus.pl_enable == 1'b0, "t6_pl_enable", bus.pl_enable, 0);
    chk(busy == 1'b0, "t6_busy", busy, 0);

    // randomized traffic with random backpressure
    do_reset();
    p0 = n_pop;
    rnd_ready = 1'b1;
    valid_pct = 60;
    for (int i = 0; i < 40; i++) host_q.push_back(mk_board(8'($urandom)));
    offer = 1'b1;
    run_cmd = 1'b1;
    wait_pops(p0 + 40, 6000, "t7_all_results");
    wait_idle(400, "t7_idle");
    rnd_ready = 1'b0;
    valid_pct = 100;
    chk(sb_q.size() == 0, "t7_scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
